// File: rtl/raccoon_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// raccoon_ctrl_pkg
// Shared constants and types for the raccoon player-control stage.
//   - Sprite and grid geometry in pixels, used by the collision test and by the
//     col/row to pixel conversion.
//   - Grid extents, the level ceiling and the gameState encodings.
//   - Button index map for the four direction inputs.
//   - rect_overlap(): pixel rectangle overlap of the raccoon against one car.
// -----------------------------------------------------------------------------
package raccoon_ctrl_pkg;

   // Sprite / cell geometry (640x480 screen, 20x16 grid)
   localparam int GRID_WIDTH    = 32;
   localparam int GRID_HEIGHT   = 30;
   localparam int PLAYER_WIDTH  = 32;
   localparam int PLAYER_HEIGHT = 30;
   localparam int CAR_WIDTH     = 64;
   localparam int CAR_HEIGHT    = 30;

   // Playfield extents and level ceiling
   localparam int GRID_COLS = 20;
   localparam int GRID_ROWS = 16;
   localparam int LEVEL_MAX = 15;

   // Button indices into the packed press vector
   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;
   localparam int NUM_BTNS  = 4;

   localparam int NUM_CARS  = 3;

   typedef enum logic [1:0] {
      ST_PLAY      = 2'd0,
      ST_HIT       = 2'd1,
      ST_GAME_OVER = 2'd2
   } game_state_t;

   // Overlap test done in 11 bits so that position + size never wraps.
   function automatic logic rect_overlap(input logic [9:0] rx,
                                         input logic [9:0] ry,
                                         input logic [9:0] cx,
                                         input logic [9:0] cy);
      logic [10:0] rx_w;
      logic [10:0] ry_w;
      logic [10:0] cx_w;
      logic [10:0] cy_w;
      logic        x_hit;
      logic        y_hit;
      rx_w  = {1'b0, rx};
      ry_w  = {1'b0, ry};
      cx_w  = {1'b0, cx};
      cy_w  = {1'b0, cy};
      x_hit = (rx_w < cx_w + 11'(CAR_WIDTH))  && (cx_w < rx_w + 11'(PLAYER_WIDTH));
      y_hit = (ry_w < cy_w + 11'(CAR_HEIGHT)) && (cy_w < ry_w + 11'(PLAYER_HEIGHT));
      return x_hit && y_hit;
   endfunction

endpackage

// File: rtl/raccoon_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Two-flop synchroniser, hold counter and rising-edge press pulse for one raw
// button.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   btn    in  raw, unsynchronised, active-high button
//   press  out one-cycle pulse when the debounced level rises
// Parameter DEBOUNCE_CYCLES: cycles the synchronised level must differ from the
// stable level before the stable level is allowed to follow it.
// -----------------------------------------------------------------------------
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press
);

   localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

   logic          sync_a;
   logic          sync_b;
   logic          stable;
   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
         stable <= 1'b0;
         count  <= '0;
         press  <= 1'b0;
      end else begin
         sync_a <= btn;
         sync_b <= sync_a;
         press  <= 1'b0;
         if (sync_b == stable) begin
            // Any bounce back to the stable level restarts the hold window.
            count <= '0;
         end else if (count == CNT_MAX) begin
            stable <= sync_b;
            count  <= '0;
            press  <= sync_b;   // pulse only on the rising flip
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/raccoon_ctrl.sv
// -----------------------------------------------------------------------------
// raccoon_ctrl
// Player-control stage ahead of the VGA renderer: debounces the direction
// buttons, steps the raccoon one grid cell per press, checks for car
// collisions and tracks lives, level and game state.
//   clk, rst_n                      clock, asynchronous active-low reset
//   btnUp/btnDown/btnLeft/btnRight  raw active-high buttons
//   carX_n, carY_n (n=1..3)         car top-left pixel positions
//   raccoonX, raccoonY              raccoon top-left pixel position (registered)
//   lives                           remaining lives
//   level                           completed crossings, saturating at 15
//   gameState                       PLAY=0, HIT=1, GAME_OVER=2
// Build option: RACCOON_WRAP_EN makes horizontal moves wrap at the left/right
// edges instead of being dropped.
// -----------------------------------------------------------------------------
module raccoon_ctrl
   import raccoon_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int HIT_HOLD_CYCLES = 12500000,
   parameter int START_LIVES     = 3,
   parameter int START_COL       = 10,
   parameter int START_ROW       = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btnUp,
   input  logic       btnDown,
   input  logic       btnLeft,
   input  logic       btnRight,
   input  logic [9:0] carX_1,
   input  logic [9:0] carY_1,
   input  logic [9:0] carX_2,
   input  logic [9:0] carY_2,
   input  logic [9:0] carX_3,
   input  logic [9:0] carY_3,
   output logic [9:0] raccoonX,
   output logic [9:0] raccoonY,
   output logic [2:0] lives,
   output logic [3:0] level,
   output logic [1:0] gameState
);

   localparam int            TW         = (HIT_HOLD_CYCLES > 1) ? $clog2(HIT_HOLD_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(HIT_HOLD_CYCLES - 1);
   localparam logic [4:0]    SPAWN_COL  = 5'(START_COL);
   localparam logic [3:0]    SPAWN_ROW  = 4'(START_ROW);
   localparam logic [2:0]    LIVES_INIT = 3'(START_LIVES);
   localparam logic [4:0]    COL_LAST   = 5'(GRID_COLS - 1);
   localparam logic [3:0]    ROW_LAST   = 4'(GRID_ROWS - 1);
   localparam logic [3:0]    LEVEL_LAST = 4'(LEVEL_MAX);
   localparam logic [9:0]    SPAWN_X    = 10'(START_COL * GRID_WIDTH);
   localparam logic [9:0]    SPAWN_Y    = 10'(START_ROW * GRID_HEIGHT);

   // ---------------------------------------------------------------- buttons
   logic [NUM_BTNS-1:0] buttons;
   logic [NUM_BTNS-1:0] press;

   always_comb begin
      buttons            = '0;
      buttons[BTN_UP]    = btnUp;
      buttons[BTN_DOWN]  = btnDown;
      buttons[BTN_LEFT]  = btnLeft;
      buttons[BTN_RIGHT] = btnRight;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BTNS; gi++) begin : g_debounce
         button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (buttons[gi]),
            .press (press[gi])
         );
      end
   endgenerate

   // -------------------------------------------------------------- collision
   logic [9:0]          car_x [NUM_CARS];
   logic [9:0]          car_y [NUM_CARS];
   logic [NUM_CARS-1:0] car_hit;
   logic                collision;

   assign car_x[0] = carX_1;
   assign car_y[0] = carY_1;
   assign car_x[1] = carX_2;
   assign car_y[1] = carY_2;
   assign car_x[2] = carX_3;
   assign car_y[2] = carY_3;

   generate
      for (gi = 0; gi < NUM_CARS; gi++) begin : g_car
         // Tested against the registered pixel position, i.e. what is on screen.
         assign car_hit[gi] = rect_overlap(raccoonX, raccoonY, car_x[gi], car_y[gi]);
      end
   endgenerate

   assign collision = |car_hit;

   // ------------------------------------------------------------- move logic
   logic [4:0] col;
   logic [3:0] row;
   logic [4:0] move_col;
   logic [3:0] move_row;

   // One move per cycle, Up > Down > Left > Right. Edge moves are dropped.
   always_comb begin
      move_col = col;
      move_row = row;
      if (press[BTN_UP]) begin
         if (row != 4'd0) move_row = row - 1'b1;
      end else if (press[BTN_DOWN]) begin
         if (row != ROW_LAST) move_row = row + 1'b1;
      end else if (press[BTN_LEFT]) begin
         if (col != 5'd0) begin
            move_col = col - 1'b1;
         end else begin
`ifdef RACCOON_WRAP_EN
            move_col = COL_LAST;
`else
            move_col = col;
`endif
         end
      end else if (press[BTN_RIGHT]) begin
         if (col != COL_LAST) begin
            move_col = col + 1'b1;
         end else begin
`ifdef RACCOON_WRAP_EN
            move_col = 5'd0;
`else
            move_col = col;
`endif
         end
      end
   end

   // -------------------------------------------------------------- game FSM
   game_state_t   state;
   game_state_t   state_next;
   logic [4:0]    col_next;
   logic [3:0]    row_next;
   logic [2:0]    lives_next;
   logic [3:0]    level_next;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_next;

   always_comb begin
      state_next = state;
      col_next   = col;
      row_next   = row;
      lives_next = lives;
      level_next = level;
      timer_next = timer;
      case (state)
         ST_PLAY: begin
            if (row == 4'd0) begin
               // Crossing completed: score it and respawn, skipping collision.
               level_next = (level == LEVEL_LAST) ? level : level + 1'b1;
               col_next   = SPAWN_COL;
               row_next   = SPAWN_ROW;
            end else if (collision) begin
               // Collision takes precedence over any move this cycle.
               lives_next = (lives == 3'd0) ? 3'd0 : lives - 1'b1;
               timer_next = '0;
               state_next = (lives <= 3'd1) ? ST_GAME_OVER : ST_HIT;
            end else begin
               col_next = move_col;
               row_next = move_row;
            end
         end
         ST_HIT: begin
            if (timer == TIMER_LAST) begin
               col_next   = SPAWN_COL;
               row_next   = SPAWN_ROW;
               timer_next = '0;
               state_next = ST_PLAY;
            end else begin
               timer_next = timer + 1'b1;
            end
         end
         ST_GAME_OVER: begin
            if (|press) begin
               lives_next = LIVES_INIT;
               level_next = 4'd0;
               col_next   = SPAWN_COL;
               row_next   = SPAWN_ROW;
               state_next = ST_PLAY;
            end
         end
         default: begin
            state_next = ST_PLAY;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_PLAY;
         col      <= SPAWN_COL;
         row      <= SPAWN_ROW;
         lives    <= LIVES_INIT;
         level    <= 4'd0;
         timer    <= '0;
         raccoonX <= SPAWN_X;
         raccoonY <= SPAWN_Y;
      end else begin
         state    <= state_next;
         col      <= col_next;
         row      <= row_next;
         lives    <= lives_next;
         level    <= level_next;
         timer    <= timer_next;
         // Pixel outputs trail col/row by one cycle.
         raccoonX <= 10'(int'(col) * GRID_WIDTH);
         raccoonY <= 10'(int'(row) * GRID_HEIGHT);
      end
   end

   assign gameState = state;

endmodule
